// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end: canonical NOP, default
// reset vector and the {pc, instr} entry handed from fetch to decode.
package riscv_pkg;

  // addi x0, x0, 0 -- presented to IF/ID whenever no real instruction is ready
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction addresses are always word aligned; the low two bits of any
  // computed target are ignored.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used by the fetch unit, once for the addresses of
// requests still in flight and once for returned {pc, instr} entries.
// Pop and push in the same cycle are allowed when full; flush empties it.
module fetch_fifo #(
  parameter  int  DEPTH = 2,
  parameter  type T     = logic [31:0],
  localparam int  AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int  CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  T              wdata,
  input  logic          pop,
  input  logic          flush,
  output T              rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage write port.
  // NOTE: the storage array has no reset; pointers and count alone decide
  // which words are valid, so leftover contents are never observable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; flush behaves like a local reset.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, issues in-order requests to a
// variable-latency instruction memory, buffers returned words and presents
// the head entry to the IF/ID register. Redirects from EX flush the buffer
// and mark every request still in flight as stale so its response is dropped.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  // Architectural fetch state
  logic [31:0]   fetch_pc;
  logic          held;        // a request was offered last cycle and refused
  logic [31:0]   held_addr;
  logic          held_stale;  // the held request predates a redirect
  logic [CW-1:0] drop_cnt;    // responses still to be discarded

  // FIFO views
  logic [CW-1:0] outstanding; // accepted requests awaiting a response
  logic [31:0]   pfifo_head;
  logic          pfifo_full;
  logic          pfifo_empty;
  fetch_entry_t  ififo_head;
  fetch_entry_t  rsp_entry;
  logic [CW-1:0] ififo_count;
  logic          ififo_full;
  logic          ififo_empty;

  // Per-cycle control
  logic          pop;
  logic          accept;
  logic          rsp_live;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          pending_next;
  logic [OW-1:0] occ_post;
  logic [CW-1:0] outstanding_next;

  // Head presentation: NOP and zero PCs whenever the buffer is empty.
  assign ValidF   = !ififo_empty;
  assign InstrF   = ValidF ? ififo_head.instr        : NOP_INSTR;
  assign PCF      = ValidF ? ififo_head.pc           : 32'h0;
  assign PCPlus4F = ValidF ? ififo_head.pc + 32'd4   : 32'h0;

  // IF/ID captures the head on the same edge that it is popped.
  assign pop = ValidF && !StallF;

  // Credit check counts in-flight plus buffered entries after this cycle's
  // pop, so a full buffer draining by one still lets a new request go out.
  assign occ_post = OW'(outstanding) + OW'(ififo_count) - OW'(pop);

  // A refused request keeps its address and valid until it is taken, even
  // if a redirect arrives meanwhile. Nothing here depends on imem_req_ready.
  assign imem_req_valid = !reset &&
                          (held || (occ_post < OW'(DEPTH) && !pfifo_full));
  assign imem_addr      = held ? held_addr : fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign pending_next   = imem_req_valid && !imem_req_ready;

  // Responses are matched to requests in order through the PC FIFO; a
  // response with nothing in flight is ignored.
  assign rsp_live = imem_rsp_valid && !pfifo_empty;
  assign rsp_drop = rsp_live && (drop_cnt != '0);
  assign rsp_keep = rsp_live && (drop_cnt == '0) && !PCSrcE &&
                    (!ififo_full || pop);

  assign outstanding_next = outstanding + CW'(accept) - CW'(rsp_live);

  assign rsp_entry = '{pc: pfifo_head, instr: imem_rsp_data};

  // Addresses of accepted requests, oldest first; its count is the
  // outstanding-request counter.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (logic [31:0])
  ) u_pc_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .wdata (imem_addr),
    .pop   (rsp_live),
    .flush (1'b0),
    .rdata (pfifo_head),
    .full  (pfifo_full),
    .empty (pfifo_empty),
    .count (outstanding)
  );

  // Returned instructions waiting for IF/ID; a redirect discards them.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_instr_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rsp_keep),
    .wdata (rsp_entry),
    .pop   (pop),
    .flush (PCSrcE),
    .rdata (ififo_head),
    .full  (ififo_full),
    .empty (ififo_empty),
    .count (ififo_count)
  );

  // PC sequencing, held-request tracking and stale-response accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      held       <= 1'b0;
      held_addr  <= RESET_PC;
      held_stale <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      held <= pending_next;
      if (pending_next) held_addr <= imem_addr;

      if (PCSrcE) begin
        // Everything still in flight after this edge, plus a refused
        // request that will eventually be taken, belongs to the old path.
        fetch_pc   <= word_align(PCTargetE);
        drop_cnt   <= outstanding_next + CW'(pending_next);
        held_stale <= pending_next;
      end else begin
        // A stale held request was issued for the old path; accepting it
        // must not advance the PC that already points at the new target.
        if (accept && !held_stale) fetch_pc <= imem_addr + 32'd4;
        if (accept)                held_stale <= 1'b0;
        if (rsp_drop)              drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined RISC-V core. Sits directly upstream of the IF/ID pipeline register. It owns the PC register and issues in-order requests to a variable-latency instruction memory. Returned instructions are buffered and presented to IF/ID as InstrF/PCF/PCPlus4F, with stall from the hazard unit and redirect from the EX stage.

## Interface
Parameters:
- DEPTH, 2: max instructions in flight plus buffered (power of two, ≥2)
- RESET_PC, 32'h0000_0000: first fetch address after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, reset synchronous and active-high
- StallF  in  1  hazard unit: hold head instruction, do not pop
- PCSrcE  in  1  EX redirect (taken branch / jump / mispredict)
- PCTargetE  in  32  redirect target; bits [1:0] ignored (treated as 0)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; responses return in request order, ≥1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- InstrF  out  32  head instruction, or NOP 32'h0000_0013 when ValidF=0
- PCF  out  32  PC of head, 0 when ValidF=0
- PCPlus4F  out  32  PCF+4 mod 2^32, 0 when ValidF=0
- ValidF  out  1  head holds a real instruction

## Operation
- State: fetch_pc (next address to request), outstanding counter (0..DEPTH), drop counter (0..DEPTH), PC FIFO of issued addresses, instruction FIFO of {pc, instr} entries.
- Issue: imem_req_valid=1 when outstanding + instr FIFO occupancy < DEPTH, or when a request is already pending unaccepted. On accept: push fetch_pc to PC FIFO, outstanding++, fetch_pc += 4 (wraps 0xFFFF_FFFC → 0).
- Held request: once imem_req_valid=1 without ready, valid and imem_addr stay stable until accepted, including across a redirect; that request is then counted as stale.
- Response: if drop counter >0, discard (drop--, outstanding--, pop PC FIFO). Else push {PC FIFO head, rsp_data} into instr FIFO, outstanding--.
- Pop: when !StallF && ValidF, head is popped at the edge; IF/ID captures the same values on that edge.
- Redirect (PCSrcE=1): at the edge, flush instr FIFO, set fetch_pc = {PCTargetE[31:2],2'b00}, drop counter = outstanding after this cycle's accept/response accounting (including the held request, if any), and clear PC FIFO entries accordingly. A response arriving in the redirect cycle is discarded.
- Priority: reset > PCSrcE > StallF. Redirect with StallF=1 still flushes. Simultaneous response and pop with a full FIFO is legal: the occupancy check uses post-pop occupancy.
- Reset mid-operation: all counters and FIFOs clear, fetch_pc=RESET_PC. Responses to pre-reset requests are the memory's responsibility to squash on reset.

## Timing
- Reset values: imem_req_valid=0, imem_addr=RESET_PC, ValidF=0, InstrF=32'h0000_0013, PCF=0, PCPlus4F=0; all counters 0.
- First request: asserted in the first cycle after reset deasserts, at addr RESET_PC.
- Response→output: response accepted in cycle N → ValidF/InstrF in cycle N+1 (no bypass).
- Redirect in cycle N → imem_addr=target with valid in N+1 (if no held request). First target instruction appears no earlier than N+3 with 1-cycle memory.
- Zero-wait memory (ready=1, rsp 1 cycle later), DEPTH=2, no stall: one instruction per cycle sustained.
- Outputs are a function of registered state only. No input→output combinational path except imem_req_valid/addr, which do not depend on imem_req_ready.

## Structure
- Shared package riscv_pkg: NOP_INSTR (32'h0000_0013), RESET_PC default, fetch-entry struct {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo: parameterised synchronous FIFO (DEPTH, element type) with push/pop/flush, full/empty, count. Instantiated twice (PC FIFO, instr FIFO).

## Test plan
- Reset, ready=1, 1-cycle rsp, StallF=0 → imem_addr 0,4,8,…; PCF 0,4,8 on consecutive cycles from cycle 3; PCPlus4F=PCF+4.
- StallF=1 for 5 cycles with DEPTH=2 → no more than 2 requests outstanding+buffered; PCF held constant; resumes with no lost or duplicated PC.
- PCSrcE=1, PCTargetE=32'h0000_0103 with 2 in flight → both stale responses dropped; next ValidF shows PCF=32'h0000_0100.
- Held request (ready=0) at addr 0x10, redirect to 0x80 → addr stays 0x10 until accepted; its response dropped; then 0x80 requested.
- fetch_pc 0xFFFF_FFFC → next request addr 0x0000_0000; PCPlus4F for that entry = 0.
- Reset asserted with FIFO full → next cycle ValidF=0, InstrF=0x13, imem_addr=RESET_PC.
